mem_switcher: RTL
=================

Name: mem_switcher

Overview:
- Memory access sequencer directly downstream of the instruction decoder.
- Consumes the decoder's ram_read/ram_write strobes, the ALU-computed address and the register write data.
- Routes each access to on-board SRAM (fixed wait states) or to the peripheral IO bus (req/ack handshake with timeout).
- Returns mem_busy/mem_ready to the decoder and read data to the register-input mux.

Parameters:
- SRAM_WAIT, 1, extra wait cycles per SRAM access (0..15); SRAM phase lasts SRAM_WAIT+1 cycles.
- IO_BASE, 16'hF000, addresses >= IO_BASE go to the IO bus; lower addresses go to SRAM.
- IO_TIMEOUT, 64, cycles io_req may stay unacknowledged before the access is aborted (2..255).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- ram_read  in  1  decoder read strobe
- ram_write  in  1  decoder write strobe
- addr  in  16  access address (ALU result)
- wdata  in  16  store data (reg_r output)
- mem_busy  out  1  access in progress; decoder must stall
- mem_ready  out  1  one-cycle pulse: read data valid
- rdata  out  16  last read result, held until the next read completes
- io_err  out  1  sticky IO timeout flag
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_addr  out  16  SRAM address
- sram_wdata  out  16  SRAM write data
- sram_rdata  in  16  SRAM read data
- io_req  out  1  IO bus request
- io_we  out  1  IO write
- io_addr  out  16  IO address
- io_wdata  out  16  IO write data
- io_rdata  in  16  IO read data
- io_ack  in  1  IO completion, sampled while io_req=1

Behaviour:
- Single clock. Reset is synchronous, active-low. All state is registered.
- Reset values: state=IDLE; mem_busy=0; mem_ready=0; rdata=0; io_err=0; sram_cs=0; sram_we=0; io_req=0; io_we=0; latched addr and data = 0.
- States:
  - IDLE: requests are accepted only here.
  - SRAM: SRAM access with wait-state counting.
  - IO: IO bus access waiting for ack or timeout.
  - DONE: read completion, ready pulse.
- Accepting a request in IDLE:
  - On ram_read or ram_write: latch addr, wdata and op. Read wins if both strobes are asserted.
  - Target: IO if addr >= IO_BASE, else SRAM.
  - Next state: SRAM (counter=SRAM_WAIT) or IO (counter=0).
- mem_busy = (state==SRAM || state==IO). It is decoded from registered state and is high from the cycle after the strobe.
- SRAM phase:
  - sram_cs=1; sram_addr and sram_wdata driven from the latches; sram_we=1 for writes for the whole phase.
  - Counter decrements each cycle.
  - At counter==0: a read captures sram_rdata into rdata and goes to DONE; a write goes to IDLE.
- IO phase:
  - io_req=1; io_addr, io_wdata and io_we driven from the latches.
  - If io_ack=1: a read captures io_rdata and goes to DONE; a write goes to IDLE. io_req drops the next cycle.
  - Else the counter increments. When counter==IO_TIMEOUT-1 without ack: abort, set io_err=1, load rdata=16'hFFFF for reads, then go to DONE (read) or IDLE (write).
- DONE: mem_ready=1 for exactly one cycle, mem_busy=0, then IDLE.
- Latency:
  - SRAM read, request at cycle 0: busy in cycles 1..SRAM_WAIT+1, ready in cycle SRAM_WAIT+2.
  - SRAM write: posted; the decoder advances at cycle 0; busy in cycles 1..SRAM_WAIT+1.
  - IO read: ready the cycle after the ack is sampled.
- Strobes arriving in SRAM, IO or DONE are ignored. The decoder never issues them there; the bench asserts they are absent.
- rdata is updated only on read completion. Writes never alter it.
- io_err clears only on reset.
- Reset mid-access returns to IDLE next edge: io_req and sram_cs drop, and no mem_ready pulse is produced.
- Address compare is unsigned. addr==IO_BASE maps to IO; addr==16'hFFFF maps to IO.

Decomposition:
- Shared package: state enum (IDLE, SRAM, IO, DONE), the IO_BASE default, and the timeout-fill constant 16'hFFFF.
- No sub-module; the wait/timeout counter stays inline.

Test Plan:
- SRAM read, SRAM_WAIT=1, addr=16'h0010, sram_rdata=16'hBEEF -> busy in cycles 1-2, mem_ready pulse in cycle 3, rdata=16'hBEEF, sram_we=0 throughout.
- SRAM write addr=16'h0020, wdata=16'h1234 -> sram_cs=sram_we=1 in cycles 1-2 with stable addr and data; no mem_ready; rdata unchanged.
- IO read addr=16'hF004, io_ack asserted in the 3rd cycle of io_req, io_rdata=16'h00A5 -> ready the next cycle, rdata=16'h00A5, io_req low after the ack.
- IO write addr=16'hF000 (boundary) with no ack, IO_TIMEOUT=64 -> io_req high for 64 cycles, io_err=1, return to IDLE, rdata unchanged; a following read timeout yields rdata=16'hFFFF.
- ram_read and ram_write asserted together at addr=16'h0003 -> read performed, sram_we never asserted.
- rst_n low during IO cycle 2 of a read -> next edge: state IDLE, io_req=0, mem_busy=0; no mem_ready pulse afterwards.

Source files
------------

// File: rtl/mem_switcher_pkg.sv
// Shared types and constants for the memory access sequencer.
// State encoding, default IO window base and timeout read fill value.
package mem_switcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SRAM = 2'd1,
        ST_IO   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] IO_BASE_DEF  = 16'hF000;
    localparam logic [15:0] TIMEOUT_FILL = 16'hFFFF;

endpackage

// File: rtl/mem_switcher_if.sv
// Decoder-side strobes/results plus the SRAM and IO bus signals.
// slave is the sequencer's view; master is the decoder/memory side.
interface mem_switcher_if;

    logic        ram_read;
    logic        ram_write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        mem_busy;
    logic        mem_ready;
    logic [15:0] rdata;
    logic        io_err;

    logic        sram_cs;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    logic        io_req;
    logic        io_we;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        io_ack;

    modport slave (
        input  ram_read, ram_write, addr, wdata,
        input  sram_rdata, io_rdata, io_ack,
        output mem_busy, mem_ready, rdata, io_err,
        output sram_cs, sram_we, sram_addr, sram_wdata,
        output io_req, io_we, io_addr, io_wdata
    );

    modport master (
        output ram_read, ram_write, addr, wdata,
        output sram_rdata, io_rdata, io_ack,
        input  mem_busy, mem_ready, rdata, io_err,
        input  sram_cs, sram_we, sram_addr, sram_wdata,
        input  io_req, io_we, io_addr, io_wdata
    );

endinterface

// File: rtl/mem_switcher.sv
// Memory access sequencer: routes decoder loads/stores to SRAM
// (fixed wait states) or the IO bus (req/ack with timeout).
module mem_switcher
    import mem_switcher_pkg::*;
#(
    parameter int unsigned SRAM_WAIT  = 1,
    parameter logic [15:0] IO_BASE    = IO_BASE_DEF,
    parameter int unsigned IO_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_switcher_if.slave  bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_SRAM = ST_SRAM;
    localparam logic [1:0] S_IO   = ST_IO;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam logic [7:0] W_INIT  = 8'(SRAM_WAIT);
    localparam logic [7:0] TO_LAST = 8'(IO_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_we;
    logic [15:0] r_rdata;
    logic        r_err;

    logic w_sram;
    logic w_io;

    assign w_sram = (r_state == S_SRAM);
    assign w_io   = (r_state == S_IO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.ram_read || bus.ram_write) begin
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        // a simultaneous read+write is treated as a read
                        r_we    <= !bus.ram_read;
                        if (bus.addr >= IO_BASE) begin
                            r_state <= S_IO;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_SRAM;
                            r_cnt   <= W_INIT;
                        end
                    end
                end
                S_SRAM: begin
                    if (r_cnt == '0) begin
                        if (r_we) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rdata <= bus.sram_rdata;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_IO: begin
                    if (bus.io_ack) begin
                        if (r_we) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rdata <= bus.io_rdata;
                            r_state <= S_DONE;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        r_err <= 1'b1;
                        if (r_we) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rdata <= TIMEOUT_FILL;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_busy   = w_sram || w_io;
    assign bus.mem_ready  = (r_state == S_DONE);
    assign bus.rdata      = r_rdata;
    assign bus.io_err     = r_err;

    assign bus.sram_cs    = w_sram;
    assign bus.sram_we    = w_sram && r_we;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_wdata = r_wdata;

    assign bus.io_req     = w_io;
    assign bus.io_we      = w_io && r_we;
    assign bus.io_addr    = r_addr;
    assign bus.io_wdata   = r_wdata;

endmodule
